// File: rtl/adc_fifo_wr_arb_pkg.sv
// adc_fifo_wr_arb_pkg
//   Shared definitions for the ADC FIFO write-side scheduler. It holds the
//   parameter legality checks used at elaboration. Flat sample and counter
//   buses are sliced by assigning them to packed 2-D arrays of the same total
//   width, so no slice macros are needed.
package adc_fifo_wr_arb_pkg;

    localparam int unsigned NCH_MIN = 2;
    localparam int unsigned NCH_MAX = 8;

    // The channel ID field must be wide enough to name every channel.
    function automatic bit cid_width_ok(input int unsigned nch, input int unsigned nbit_cid);
        return (nbit_cid < 32) && ((32'd1 << nbit_cid) >= nch);
    endfunction

    function automatic bit nch_ok(input int unsigned nch);
        return (nch >= NCH_MIN) && (nch <= NCH_MAX);
    endfunction

endpackage

// File: rtl/adc_fifo_wr_arb_if.sv
// adc_fifo_wr_arb_if
//   Bundles the channel capture inputs, the FIFO write port and the status
//   outputs of adc_fifo_wr_arb.
//   slave  : the scheduler side (captures strobes, drives wr/wdata/status)
//   master : the environment side (ADC channels, FIFO, control)
interface adc_fifo_wr_arb_if #(
    parameter int p_nch      = 4,
    parameter int p_nbit_cid = 2,
    parameter int p_nbit_s   = 14,
    parameter int p_nbit_dc  = 8
);
    logic                           en;
    logic [p_nch-1:0]               ch_stb;
    logic [p_nch*p_nbit_s-1:0]      ch_data;
    logic                           cnt_clr;
    logic                           wfull;
    logic                           wr;
    logic [p_nbit_cid+p_nbit_s-1:0] wdata;
    logic                           busy;
    logic [p_nch-1:0]               ovf;
    logic [p_nch*p_nbit_dc-1:0]     drop_cnt;

    modport slave (
        input  en, ch_stb, ch_data, cnt_clr, wfull,
        output wr, wdata, busy, ovf, drop_cnt
    );

    modport master (
        output en, ch_stb, ch_data, cnt_clr, wfull,
        input  wr, wdata, busy, ovf, drop_cnt
    );
endinterface

// File: rtl/adc_fifo_wr_arb_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a registered "last granted" pointer.
//   Ports: wclk, wrst (sync active-high), req[p_n], adv (commit the current
//   grant), grant[p_n] one-hot, combinational from req and the pointer.
//   After reset the pointer sits at p_n-1, so index 0 has first priority.
module rr_arbiter #(
    parameter int p_n = 4
) (
    input  logic           wclk,
    input  logic           wrst,
    input  logic [p_n-1:0] req,
    input  logic           adv,
    output logic [p_n-1:0] grant
);
    localparam int W = (p_n > 1) ? $clog2(p_n) : 1;

    logic [W-1:0] last_q, last_d;
    logic [W-1:0] gidx;
    logic         found;
    int           idx;

    // Search last+1 .. last+p_n (wrapping), so the previous winner is checked last.
    always_comb begin
        grant = '0;
        gidx  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= p_n; k++) begin
            idx = int'(last_q) + k;
            if (idx >= p_n) idx = idx - p_n;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = W'(idx);
            end
        end
        last_d = adv ? gidx : last_q;
    end

    always_ff @(posedge wclk) begin
        if (wrst) last_q <= W'(p_n - 1);
        else      last_q <= last_d;
    end
endmodule

// File: rtl/adc_fifo_wr_arb.sv
// adc_fifo_wr_arb
//   Write-side scheduler for the asynchronous sample FIFO (write clock domain).
//   Each channel strobe is captured into a one-entry holding register. The
//   pending registers share the FIFO write port round-robin, and each written
//   word is tagged {cid, sample}. A strobe that finds its holding register
//   still occupied (and not being written this cycle) is dropped: it sets a
//   sticky ovf bit and bumps a saturating drop counter.
//   Ports: wclk, wrst (sync active-high), bus (adc_fifo_wr_arb_if.slave):
//     en, ch_stb, ch_data, cnt_clr, wfull -> wr, wdata, busy, ovf, drop_cnt.
module adc_fifo_wr_arb
    import adc_fifo_wr_arb_pkg::*;
#(
    parameter int p_nch      = 4,
    parameter int p_nbit_cid = 2,
    parameter int p_nbit_s   = 14,
    parameter int p_nbit_dc  = 8
) (
    input  logic              wclk,
    input  logic              wrst,
    adc_fifo_wr_arb_if.slave  bus
);
    if (!cid_width_ok(p_nch, p_nbit_cid) || !nch_ok(p_nch)) begin : g_bad_param
        $error("adc_fifo_wr_arb: illegal p_nch / p_nbit_cid combination");
    end

    logic [p_nch-1:0][p_nbit_s-1:0]  sample;
    logic [p_nch-1:0][p_nbit_s-1:0]  hold_q, hold_d;
    logic [p_nch-1:0]                pend_q, pend_d;
    logic [p_nch-1:0]                ovf_q, ovf_d;
    logic [p_nch-1:0][p_nbit_dc-1:0] dcnt_q, dcnt_d;
    logic [p_nch-1:0]                req, grant, cap, drop;
    logic                            wr;
    logic [p_nbit_cid+p_nbit_s-1:0]  wdata;

    assign sample = bus.ch_data;

    // wfull blocks every request. Reset also blocks them, so no word leaves
    // in the cycle that discards the holding registers. Every wr is accepted.
    assign req = pend_q & {p_nch{~bus.wfull & ~wrst}};
    assign wr  = |req;

    rr_arbiter #(.p_n(p_nch)) u_arb (
        .wclk  (wclk),
        .wrst  (wrst),
        .req   (req),
        .adv   (wr),
        .grant (grant)
    );

    always_comb begin
        wdata  = '0;
        hold_d = hold_q;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        dcnt_d = dcnt_q;
        cap    = '0;
        drop   = '0;
        for (int i = 0; i < p_nch; i++) begin
            if (grant[i]) wdata = {p_nbit_cid'(i), hold_q[i]};

            // A channel being written this cycle frees its slot at the same
            // edge, so a back-to-back strobe is captured rather than dropped.
            cap[i]  = bus.en & bus.ch_stb[i] & (~pend_q[i] | grant[i]);
            drop[i] = bus.en & bus.ch_stb[i] & pend_q[i] & ~grant[i];

            if (cap[i]) begin
                hold_d[i] = sample[i];
                pend_d[i] = 1'b1;
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end

            // Clear wins over a coincident drop.
            if (bus.cnt_clr) begin
                ovf_d[i]  = 1'b0;
                dcnt_d[i] = '0;
            end else if (drop[i]) begin
                ovf_d[i] = 1'b1;
                if (dcnt_q[i] != {p_nbit_dc{1'b1}}) dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            hold_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            dcnt_q <= '0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign bus.wr       = wr;
    assign bus.wdata    = wdata;
    assign bus.busy     = |pend_q;
    assign bus.ovf      = ovf_q;
    assign bus.drop_cnt = dcnt_q;
endmodule

// File: tb/tb_adc_fifo_wr_arb.sv
// tb_adc_fifo_wr_arb
//   Directed bench for adc_fifo_wr_arb (4 channels, 14-bit samples). Each
//   table vector drives one cycle of inputs and gives the wr / wdata / busy
//   expected in that cycle, before the edge that registers those inputs.
//   Saturation, clear and enable cases are written out by hand.
module tb_adc_fifo_wr_arb;
    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    adc_fifo_wr_arb_if bus ();

    adc_fifo_wr_arb dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic             rst;
        logic [3:0]       stb;
        logic [3:0][13:0] d;
        logic             wfull;
        logic             xwr;
        logic [15:0]      xwdata;
        logic             xbusy;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   vnum   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] stb,
                                input logic [13:0] d0, input logic [13:0] d1,
                                input logic [13:0] d2, input logic [13:0] d3,
                                input logic wfull, input logic xwr,
                                input logic [15:0] xwdata, input logic xbusy);
        vec_t v;
        v.rst = rst; v.stb = stb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.wfull = wfull; v.xwr = xwr; v.xwdata = xwdata; v.xbusy = xbusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [3:0] stb,
                         input logic [3:0][13:0] d, input logic clr, input logic wfull);
        wrst        = rst;
        bus.en      = en;
        bus.ch_stb  = stb;
        bus.ch_data = d;
        bus.cnt_clr = clr;
        bus.wfull   = wfull;
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic run_vecs();
        foreach (vq[i]) begin
            drive(vq[i].rst, 1'b1, vq[i].stb, vq[i].d, 1'b0, vq[i].wfull);
            @(negedge wclk);
            chk($sformatf("v%0d wr", vnum),    32'(bus.wr),    32'(vq[i].xwr));
            chk($sformatf("v%0d wdata", vnum), 32'(bus.wdata), 32'(vq[i].xwdata));
            chk($sformatf("v%0d busy", vnum),  32'(bus.busy),  32'(vq[i].xbusy));
            vnum++;
            step();
        end
        vq.delete();
    endtask

    initial begin
        logic [3:0][13:0] d;
        d = '0;
        drive(1'b1, 1'b0, 4'b0000, d, 1'b0, 1'b0);
        step();
        step();
        chk("rst wr",    32'(bus.wr), 0);
        chk("rst wdata", 32'(bus.wdata), 0);
        chk("rst busy",  32'(bus.busy), 0);
        chk("rst ovf",   32'(bus.ovf), 0);
        chk("rst drop",  32'(bus.drop_cnt), 0);

        // single strobe on ch2
        vq.push_back(mk(0, 4'b0100, 0, 0, 14'h1ABC, 0, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h9ABC, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        // reset, then all four channels at once: ch0 first
        vq.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h0001, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h4002, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h8003, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'hC004, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        // ch1/ch3 alternate; each re-strobes in its own grant cycle
        vq.push_back(mk(0, 4'b1010, 0, 14'h101, 0, 14'h301, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0010, 0, 14'h102, 0, 0, 0, 1, 16'h4101, 1));
        vq.push_back(mk(0, 4'b1000, 0, 0, 0, 14'h302, 0, 1, 16'hC301, 1));
        vq.push_back(mk(0, 4'b0010, 0, 14'h103, 0, 0, 0, 1, 16'h4102, 1));
        vq.push_back(mk(0, 4'b1000, 0, 0, 0, 14'h303, 0, 1, 16'hC302, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h4103, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'hC303, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        run_vecs();
        chk("alt ovf",  32'(bus.ovf), 0);
        chk("alt drop", 32'(bus.drop_cnt), 0);

        // wfull held: first strobe is kept, the next two drop
        vq.push_back(mk(0, 4'b0001, 14'h0AA, 0, 0, 0, 1, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0001, 14'h0BB, 0, 0, 0, 1, 0, 16'h0000, 1));
        vq.push_back(mk(0, 4'b0001, 14'h0CC, 0, 0, 0, 1, 0, 16'h0000, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 16'h0000, 1));
        run_vecs();
        chk("full ovf",   32'(bus.ovf), 32'h1);
        chk("full drop0", 32'(bus.drop_cnt[7:0]), 2);
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h00AA, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        run_vecs();

        // drop counter saturation, clear-vs-drop, en=0
        d = '0; d[1] = 14'h555;
        drive(1'b0, 1'b1, 4'b0010, d, 1'b0, 1'b1);
        step();
        d[1] = 14'h666;
        drive(1'b0, 1'b1, 4'b0010, d, 1'b0, 1'b1);
        repeat (300) step();
        chk("sat drop1", 32'(bus.drop_cnt[15:8]), 32'hFF);
        chk("sat ovf",   32'(bus.ovf), 32'h3);
        drive(1'b0, 1'b1, 4'b0010, d, 1'b1, 1'b1);
        step();
        chk("clr drop", 32'(bus.drop_cnt), 0);
        chk("clr ovf",  32'(bus.ovf), 0);
        drive(1'b0, 1'b0, 4'b0010, d, 1'b0, 1'b1);
        step();
        chk("en0 drop", 32'(bus.drop_cnt), 0);
        chk("en0 ovf",  32'(bus.ovf), 0);
        drive(1'b0, 1'b1, 4'b0000, d, 1'b0, 1'b0);
        @(negedge wclk);
        chk("drain wr",    32'(bus.wr), 1);
        chk("drain wdata", 32'(bus.wdata), 32'h4555);
        step();
        chk("drain busy", 32'(bus.busy), 0);

        // reset with ch0/ch1 pending; pointer was left on ch0, so after reset
        // ch0 must still win over ch1
        vq.push_back(mk(0, 4'b0001, 14'h007, 0, 0, 0, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h0007, 1));
        vq.push_back(mk(0, 4'b0011, 14'h111, 14'h222, 0, 0, 1, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 0, 16'h0000, 1));
        vq.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0011, 14'h011, 14'h022, 0, 0, 0, 0, 16'h0000, 0));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h0011, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1, 16'h4022, 1));
        vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
